sp_ram_mbist: RTL and testbench

//  Single-port RAM wrapper with an on-chip March C- self-test engine, plus optional zero-init on reset.

---
 rtl/sram_mbist_pkg.sv | 42 ++++
 rtl/sp_ram_mbist_if.sv | 16 +
 rtl/sp_ram_mbist_march_ctrl.sv | 116 +++++++++++
 rtl/sp_ram_mbist.sv | 132 +++++++++++++
 tb/tb_sp_ram_mbist.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_mbist_pkg.sv
// Shared types and the March C- element table for the self-testing single-port RAM.
package sram_mbist_pkg;
    localparam int ELEM_W = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } march_state_e;

    typedef enum logic [ELEM_W-1:0] {
        E_M0, E_M1, E_M2, E_M3, E_M4, E_M5
    } march_elem_e;

    // rd_val/wr_val are the replicated bit value: 0 = all-0 word, 1 = all-1 word
    typedef struct packed {
        logic down;
        logic rd;
        logic wr;
        logic rd_val;
        logic wr_val;
    } march_op_t;

    function automatic march_op_t march_op(input logic [ELEM_W-1:0] elem);
        march_op_t op;
        op = '0;
        case (elem)
            E_M0:    op = '{down: 1'b0, rd: 1'b0, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
            E_M1:    op = '{down: 1'b0, rd: 1'b1, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            E_M2:    op = '{down: 1'b0, rd: 1'b1, wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            E_M3:    op = '{down: 1'b1, rd: 1'b1, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            E_M4:    op = '{down: 1'b1, rd: 1'b1, wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            E_M5:    op = '{down: 1'b0, rd: 1'b1, wr: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
            default: op = '0;
        endcase
        return op;
    endfunction

    function automatic logic elem_down(input logic [ELEM_W-1:0] elem);
        march_op_t op;
        op = march_op(elem);
        return op.down;
    endfunction
endpackage

// File: rtl/sp_ram_mbist_if.sv
// User access port of the self-testing single-port RAM.
interface sp_ram_mbist_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_COL    = 4
);
    logic                  clk_en;
    logic                  rdw_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [NUM_COL-1:0]    data_mask_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (output clk_en, rdw_en, addr, data_in, data_mask_in, input data_out);
    modport slave  (input clk_en, rdw_en, addr, data_in, data_mask_in, output data_out);
endinterface

// File: rtl/sp_ram_mbist_march_ctrl.sv
// March C- sequencer: element FSM, address counter and one-cycle-delayed read compare.
module mbist_march_ctrl
    import sram_mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  init_done,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ELEM_W-1:0]     fail_elem
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    march_state_e          st;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  ph;
    logic                  in_elem, do_rd, do_wr, step, last;
    logic [ELEM_W-1:0]     elem;
    march_op_t             op;

    logic                  exp_vld;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [ELEM_W-1:0]     exp_elem;

    assign in_elem = (st >= S_M0) && (st <= S_M5);
    assign elem    = ELEM_W'(st - S_M0);
    assign op      = march_op(elem);

    // r/w elements spend two cycles per address: ph=0 reads, ph=1 writes
    assign do_rd = in_elem && op.rd && (!op.wr || !ph);
    assign do_wr = in_elem && op.wr && (!op.rd || ph);
    assign step  = in_elem && (!(op.rd && op.wr) || ph);
    assign last  = op.down ? (cnt == '0) : (cnt == ADDR_MAX);

    assign mem_en    = do_rd || do_wr;
    assign mem_we    = do_wr;
    assign mem_addr  = cnt;
    assign mem_wdata = {DATA_WIDTH{op.wr_val}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            cnt       <= '0;
            ph        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            exp_vld   <= 1'b0;
            exp_data  <= '0;
            exp_addr  <= '0;
            exp_elem  <= '0;
        end else begin
            exp_vld <= do_rd;
            if (do_rd) begin
                exp_data <= {DATA_WIDTH{op.rd_val}};
                exp_addr <= cnt;
                exp_elem <= elem;
            end
            if (exp_vld && (rdata != exp_data)) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= exp_addr;
                    fail_elem <= exp_elem;
                end
            end

            case (st)
                S_IDLE: begin
                    if (start && init_done) begin
                        st        <= S_M0;
                        cnt       <= '0;
                        ph        <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                    end
                end
                S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                    if (op.rd && op.wr) ph <= ~ph;
                    if (step) begin
                        if (last) begin
                            cnt <= elem_down(elem + ELEM_W'(1)) ? ADDR_MAX : '0;
                            st  <= (st == S_M5) ? S_DRAIN : march_state_e'(st + 4'd1);
                        end else begin
                            cnt <= op.down ? cnt - 1'b1 : cnt + 1'b1;
                        end
                    end
                end
                // last M5 read is compared during this cycle
                S_DRAIN: begin
                    st   <= S_DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                S_DONE:  st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/sp_ram_mbist.sv
// Single-port RAM with column write mask, optional zero-init after reset and a March C- BIST.
module sp_ram_mbist
    import sram_mbist_pkg::*;
#(
    parameter int ADDR_WIDTH              = 6,
    parameter int DATA_WIDTH              = 32,
    parameter int COL_WIDTH               = 8,
    parameter bit INSTANTIATE_ASIC_MEMORY = 1'b0,
    parameter bit INIT_MEMORY_ON_RESET    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sp_ram_mbist_if.slave         bus,
    output logic                  init_done,
    input  logic                  mbist_start,
    output logic                  mbist_busy,
    output logic                  mbist_done,
    output logic                  mbist_fail,
    output logic [ADDR_WIDTH-1:0] mbist_fail_addr,
    output logic [ELEM_W-1:0]     mbist_fail_elem
);
    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam int                    NUM_COL  = DATA_WIDTH / COL_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    if (DATA_WIDTH % COL_WIDTH != 0) begin : g_bad_col
        $fatal(1, "DATA_WIDTH must be a multiple of COL_WIDTH");
    end

    logic                  init_busy;
    logic [ADDR_WIDTH-1:0] init_cnt;

    if (INIT_MEMORY_ON_RESET) begin : g_init
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                init_busy <= 1'b1;
                init_cnt  <= '0;
                init_done <= 1'b0;
            end else if (init_busy) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == ADDR_MAX) begin
                    init_busy <= 1'b0;
                    init_done <= 1'b1;
                end
            end
        end
    end else begin : g_no_init
        assign init_busy = 1'b0;
        assign init_cnt  = '0;
        assign init_done = 1'b1;
    end

    logic                  b_en, b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic [DATA_WIDTH-1:0] data_q;

    mbist_march_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mbist_start),
        .init_done (init_done),
        .rdata     (data_q),
        .mem_en    (b_en),
        .mem_we    (b_we),
        .mem_addr  (b_addr),
        .mem_wdata (b_wdata),
        .busy      (mbist_busy),
        .done      (mbist_done),
        .fail      (mbist_fail),
        .fail_addr (mbist_fail_addr),
        .fail_elem (mbist_fail_elem)
    );

    logic                  m_en, m_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [NUM_COL-1:0]    m_mask;

    // init wins over BIST, BIST over user; user accesses lost while either is active
    always_comb begin
        m_en    = bus.clk_en;
        m_we    = bus.rdw_en;
        m_addr  = bus.addr;
        m_wdata = bus.data_in;
        m_mask  = bus.data_mask_in;
        if (init_busy) begin
            m_en    = 1'b1;
            m_we    = 1'b1;
            m_addr  = init_cnt;
            m_wdata = '0;
            m_mask  = '1;
        end else if (mbist_busy) begin
            m_en    = b_en;
            m_we    = b_we;
            m_addr  = b_addr;
            m_wdata = b_wdata;
            m_mask  = '1;
        end
        if (!rst_n) m_en = 1'b0;
    end

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    if (INSTANTIATE_ASIC_MEMORY) begin : g_asic
        // behavioural view of the macro interface: per-bit write enables
        logic [DATA_WIDTH-1:0] bit_mask;
        for (genvar c = 0; c < NUM_COL; c++) begin : g_bmask
            assign bit_mask[c*COL_WIDTH +: COL_WIDTH] = {COL_WIDTH{m_mask[c]}};
        end
        always_ff @(posedge clk) begin
            if (m_en) begin
                if (m_we) mem[m_addr] <= (mem[m_addr] & ~bit_mask) | (m_wdata & bit_mask);
                else      data_q      <= mem[m_addr];
            end
        end
    end else begin : g_model
        always_ff @(posedge clk) begin
            if (m_en) begin
                if (m_we) begin
                    for (int c = 0; c < NUM_COL; c++)
                        if (m_mask[c])
                            mem[m_addr][c*COL_WIDTH +: COL_WIDTH] <= m_wdata[c*COL_WIDTH +: COL_WIDTH];
                end else begin
                    data_q <= mem[m_addr];
                end
            end
        end
    end

    assign bus.data_out = data_q;
endmodule

// File: tb/tb_sp_ram_mbist.sv
// Scoreboard bench for sp_ram_mbist: stimulus pushes expectations, a monitor pops on DUT output.
module tb_sp_ram_mbist;
    import sram_mbist_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int NC = DW / CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mbist_start = 1'b0;
    logic          init_done, mbist_busy, mbist_done, mbist_fail;
    logic [AW-1:0] mbist_fail_addr;
    logic [ELEM_W-1:0] mbist_fail_elem;

    int checks = 0;
    int failures = 0;

    typedef struct { string name; logic [DW-1:0] data; } rd_exp_t;
    typedef struct { string name; int cycles; logic fail; logic [AW-1:0] addr; logic [ELEM_W-1:0] elem; } mb_exp_t;

    rd_exp_t rd_q[$];
    mb_exp_t mb_q[$];
    rd_exp_t re;
    mb_exp_t me;
    logic    rd_fire = 1'b0;
    int      busy_cnt = 0;
    logic    busy_prev = 1'b0;
    logic    done_prev = 1'b0;

    sp_ram_mbist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_COL(NC)) bus ();

    sp_ram_mbist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COL_WIDTH(CW),
        .INSTANTIATE_ASIC_MEMORY(1'b0), .INIT_MEMORY_ON_RESET(1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .init_done       (init_done),
        .mbist_start     (mbist_start),
        .mbist_busy      (mbist_busy),
        .mbist_done      (mbist_done),
        .mbist_fail      (mbist_fail),
        .mbist_fail_addr (mbist_fail_addr),
        .mbist_fail_elem (mbist_fail_elem)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a read issued at one edge is compared on the following negedge
    always @(posedge clk) rd_fire <= bus.clk_en && !bus.rdw_en;

    initial forever begin
        @(negedge clk);
        if (rd_fire) begin
            if (rd_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
            else begin
                re = rd_q.pop_front();
                check(re.name, 32'(bus.data_out), 32'(re.data));
            end
        end
        if (mbist_busy) busy_cnt = busy_prev ? busy_cnt + 1 : 1;
        if (mbist_done && !done_prev) begin
            if (mb_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                me = mb_q.pop_front();
                check({me.name, "_busy_cycles"}, busy_cnt, me.cycles);
                check({me.name, "_busy_low"}, 32'(mbist_busy), 32'd0);
                check({me.name, "_fail"}, 32'(mbist_fail), 32'(me.fail));
                check({me.name, "_fail_addr"}, 32'(mbist_fail_addr), 32'(me.addr));
                check({me.name, "_fail_elem"}, 32'(mbist_fail_elem), 32'(me.elem));
            end
        end
        busy_prev = mbist_busy;
        done_prev = mbist_done;
    end

    task automatic user_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        @(posedge clk); #1;
        bus.clk_en = 1'b1; bus.rdw_en = 1'b0; bus.addr = a;
        rd_q.push_back('{name: name, data: exp});
        @(posedge clk); #1;
        bus.clk_en = 1'b0;
    endtask

    task automatic user_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NC-1:0] m);
        @(posedge clk); #1;
        bus.clk_en = 1'b1; bus.rdw_en = 1'b1; bus.addr = a; bus.data_in = d; bus.data_mask_in = m;
        @(posedge clk); #1;
        bus.clk_en = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 mbist_start = 1'b1;
        @(posedge clk); #1 mbist_start = 1'b0;
    endtask

    task automatic wait_init(input string name, input bit poke_start);
        int n = 0;
        while (!init_done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (poke_start && n == 5) mbist_start = 1'b1;
            if (n == 6) mbist_start = 1'b0;
        end
        check(name, n, 16);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(mbist_done && !mbist_busy) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_finished"}, 32'(mbist_done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clk_en = 1'b0; bus.rdw_en = 1'b0; bus.addr = '0; bus.data_in = '0; bus.data_mask_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(mbist_busy), 32'd0);
        check("rst_done", 32'(mbist_done), 32'd0);
        check("rst_fail", 32'(mbist_fail), 32'd0);
        check("rst_fail_addr", 32'(mbist_fail_addr), 32'd0);
        check("rst_fail_elem", 32'(mbist_fail_elem), 32'd0);

        // start pulsed while init runs must be dropped
        rst_n = 1'b1;
        wait_init("init_cycles", 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("start_in_init_busy", 32'(mbist_busy), 32'd0);
        check("start_in_init_done", 32'(mbist_done), 32'd0);

        user_read(4'd7, 8'h00, "rd_addr7_after_init");
        user_write(4'd3, 8'hAB, 2'b01);
        user_read(4'd3, 8'h0B, "rd_addr3_masked");

        // clean run with a stray start and a user write landing mid-test
        mb_q.push_back('{name: "clean_run", cycles: 161, fail: 1'b0, addr: '0, elem: '0});
        start_pulse();
        repeat (20) @(posedge clk);
        #1;
        mbist_start = 1'b1;
        bus.clk_en = 1'b1; bus.rdw_en = 1'b1; bus.addr = 4'd9; bus.data_in = 8'hFF; bus.data_mask_in = 2'b11;
        @(posedge clk); #1;
        mbist_start = 1'b0; bus.clk_en = 1'b0;
        wait_done("clean_run");
        for (int i = 0; i < 16; i++) user_read(AW'(i), 8'h00, $sformatf("rd_after_clean_%0d", i));
        check("done_level_held", 32'(mbist_done), 32'd1);

        // bit 0 of word 5 stuck at 1: first caught by the M1 read
        force dut.mem[5][0] = 1'b1;
        mb_q.push_back('{name: "stuck_bit", cycles: 161, fail: 1'b1, addr: 4'd5, elem: 3'd1});
        start_pulse();
        wait_done("stuck_bit");
        repeat (2) @(posedge clk);
        release dut.mem[5][0];

        // reset in the middle of a run
        start_pulse();
        repeat (49) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(mbist_busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(mbist_busy), 32'd0);
        check("abort_done", 32'(mbist_done), 32'd0);
        check("abort_fail", 32'(mbist_fail), 32'd0);
        check("abort_init_done", 32'(init_done), 32'd0);
        rst_n = 1'b1;
        wait_init("reinit_cycles", 1'b0);

        mb_q.push_back('{name: "rerun", cycles: 161, fail: 1'b0, addr: '0, elem: '0});
        start_pulse();
        wait_done("rerun");
        user_read(4'd5, 8'h00, "rd_addr5_after_rerun");
        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_drained", rd_q.size(), 0);
        check("mb_queue_drained", mb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
